// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample format, volume width, fetch FSM encoding
// and the volume scaling law used by the sample fetcher.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 2;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT
    } fetch_state_t;

    // Scale around the midpoint: volume v keeps s >>> (3-v), volume 0 is silence.
    function automatic logic [SAMPLE_W-1:0] scale_sample(
        input logic [SAMPLE_W-1:0] data,
        input logic [VOL_W-1:0]    vol
    );
        logic signed [SAMPLE_W:0] centered;
        logic signed [SAMPLE_W:0] shifted;
        logic [SAMPLE_W-1:0]      scaled;
        centered = $signed({1'b0, data} - 9'd128);
        shifted  = centered >>> (2'd3 - vol);
        scaled   = shifted[SAMPLE_W-1:0] + SAMPLE_MID;
        if (vol == '0) begin
            scaled = SAMPLE_MID;
        end
        return scaled;
    endfunction

endpackage

// File: rtl/sample_tick_sync.sv
// Brings the divided sample clock into the clk domain and turns each rising
// edge into a single-cycle tick.
module sample_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic s1, s2, s3;

    // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

endmodule

// File: rtl/pcm_sample_fetcher.sv
// Fetches one PCM sample per sample tick from the song ROM, applies volume and
// hands it to the PWM stage; also tracks playback progress and song end.
module pcm_sample_fetcher
    import audio_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int SONG_LEN = 48000,
    parameter int ROM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_sample_rate,
    input  logic                song_pause,
    input  logic [VOL_W-1:0]    volume,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_rd,
    input  logic [SAMPLE_W-1:0] rom_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic [7:0]          progress,
    output logic                song_end
);

    localparam int FRAC_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
    localparam logic [FRAC_W-1:0] SONG_LEN_F = FRAC_W'(SONG_LEN);
    localparam logic [FRAC_W-1:0] FRAC_STEP  = FRAC_W'(256);
    localparam logic [2:0]        LAT_LAST   = 3'(ROM_LAT);

    fetch_state_t      state;
    logic              tick;
    logic [2:0]        wait_cnt;
    logic [FRAC_W-1:0] frac;
    logic [FRAC_W-1:0] frac_sum;

    sample_tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (clk_sample_rate),
        .tick     (tick)
    );

    assign frac_sum = frac + FRAC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            frac         <= '0;
            rom_addr     <= '0;
            rom_rd       <= 1'b0;
            sample_out   <= SAMPLE_MID;
            sample_valid <= 1'b0;
            progress     <= '0;
            song_end     <= 1'b0;
        end else begin
            rom_rd       <= 1'b0;
            sample_valid <= 1'b0;
            song_end     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick && song_pause) begin
                        sample_out   <= SAMPLE_MID;
                        sample_valid <= 1'b1;
                        state        <= EMIT;
                    end else if (tick) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    rom_rd   <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Data for the read is on rom_data during the ROM_LAT-th cycle after rom_rd.
                    if (wait_cnt == LAT_LAST) begin
                        sample_out   <= scale_sample(rom_data, volume);
                        sample_valid <= 1'b1;
                        state        <= EMIT;
                        if (rom_addr == LAST_ADDR) begin
                            rom_addr <= '0;
                            frac     <= '0;
                            progress <= '0;
                            song_end <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            if (frac_sum >= SONG_LEN_F) begin
                                frac <= frac_sum - SONG_LEN_F;
                                if (progress != 8'hFF) begin
                                    progress <= progress + 8'd1;
                                end
                            end else begin
                                frac <= frac_sum;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                EMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pcm_sample_fetcher.md
Name: pcm_sample_fetcher

Overview:
- Audio source stage directly upstream of the DAC/PWM stage.
- On each rising edge of the divided sample-rate clock, it reads one 8-bit unsigned PCM sample from the song ROM and applies the 2-bit volume.
- It then presents the sample to the PWM modulator with a one-cycle valid strobe.
- It also produces the 8-bit playback progress consumed by the VGA stage and a song-end pulse.

Parameters:
- ADDR_W, 16, ROM address width.
- SONG_LEN, 48000, number of samples in the song; legal range 256 to 2^ADDR_W.
- ROM_LAT, 1, cycles from rom_rd to valid rom_data; legal range 1 to 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- clk_sample_rate  in  1  divided sample clock (8 kHz), treated as asynchronous.
- song_pause  in  1  1 = paused.
- volume  in  2  0 = mute, 3 = full scale.
- rom_addr  out  ADDR_W  sample ROM address.
- rom_rd  out  1  one-cycle read strobe.
- rom_data  in  8  unsigned PCM sample.
- sample_out  out  8  unsigned sample to PWM stage; 128 = silence.
- sample_valid  out  1  one-cycle strobe; sample_out changes only with it.
- progress  out  8  0..255 fraction of song played.
- song_end  out  1  one-cycle pulse on wrap to address 0.

Behaviour:
- Reset values: rom_addr=0, rom_rd=0, sample_out=8'd128, sample_valid=0, progress=0, song_end=0. Reset also clears the FSM (to IDLE), sync flops and progress accumulator.
- Reset mid-fetch aborts the fetch; no sample_valid follows.
- Tick generation:
  - clk_sample_rate passes through a 2-flop synchronizer plus one history flop.
  - tick = s2 & ~s3, high for exactly one clk cycle per rising edge.
- FSM states and transitions:
  - IDLE: on tick with song_pause=0, go to FETCH. On tick with song_pause=1, go to EMIT with silence, with no ROM access and no address advance.
  - FETCH: rom_rd=1 for one cycle with rom_addr=current address, then go to WAIT.
  - WAIT: count ROM_LAT cycles, capture rom_data on the final one, then go to EMIT.
  - EMIT: register sample_out and pulse sample_valid=1, advance the address/progress if the fetch was not a pause, then return to IDLE.
- Latency:
  - rom_rd is asserted 3 cycles after the first clk edge that samples clk_sample_rate high.
  - sample_valid is asserted ROM_LAT+1 cycles after rom_rd.
- A tick arriving outside IDLE is ignored.
- Pause handling:
  - song_pause is sampled only in IDLE at the tick.
  - A fetch already in progress completes normally.
  - While paused, every tick emits 128 and rom_addr holds; on release, playback resumes at the held address.
- Volume scaling (volume sampled at the capture cycle):
  - s = rom_data - 128, as 9-bit signed.
  - volume 0: out = 128.
  - volume v = 1..3: out = (s >>> (3-v)) + 128.
  - No clipping is needed; the result always lies in 0..255.
- Address: increments after each non-pause emit. At SONG_LEN-1 it wraps to 0 and song_end pulses in the same cycle as sample_valid.
- Progress (no divider):
  - frac register, width ADDR_W+1.
  - Per advance: frac += 256; if frac >= SONG_LEN, then frac -= SONG_LEN and progress++, saturating at 255.
  - At most one increment per sample, since SONG_LEN >= 256.
  - On wrap, frac and progress are cleared to 0; the wrap has priority over the increment.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_MID = 8'd128
  - VOL_W = 2
  - the FSM state encoding (IDLE, FETCH, WAIT, EMIT)
  - SAMPLE_W = 8
- One sub-module, sample_tick_sync: the 2-flop synchronizer plus edge detector, producing tick. It is reused by the DAC stage.

Test Plan:
- Reset: hold rst 3 cycles with clk_sample_rate toggling -> sample_out=128, progress=0, rom_addr=0, no rom_rd or sample_valid during reset.
- Latency/full scale: volume=3, ROM returns 0xFF at addr 0, ROM_LAT=1, one sample edge -> rom_rd 3 cycles after the edge; 2 cycles later sample_valid=1 with sample_out=0xFF; rom_addr becomes 1.
- Volume law:
  - data 0x00, volume=1 -> 0x60.
  - data 0xFF, volume=2 -> 0xBF.
  - data 0xFF, volume=0 -> 0x80.
  - data 0x80, any volume -> 0x80.
- Progress/wrap with SONG_LEN=512:
  - progress=1 after sample 2 and 255 after sample 510.
  - On the 512th emit, rom_addr=0, song_end pulses once and progress=0.
- Pause: assert song_pause at addr 10 over 5 ticks -> 5 sample_valid pulses with 128, rom_addr stays 10, no rom_rd; release -> next rom_rd at addr 10.
- Reset during WAIT (ROM_LAT=4): assert rst 2 cycles after rom_rd -> no sample_valid; all outputs at reset values on the next cycle.
